run_controller: RTL and testbench

//   Parametrised run controller for the RISC workbench: sequences N CPU instances through reset,
//   run and completion. Holds each CPU in reset for a programmable time, then counts run cycles.

---
 rtl/run_controller.sv | 155 +++++++++++++++
 tb/tb_run_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run controller: walks NUM_CPUS CPU channels through reset, run and completion,
// timestamping each channel's first halt and flagging a timeout if any never halts.
module run_controller #(
  parameter int NUM_CPUS       = 2,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CYC_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_CPUS-1:0]       halt,
  output logic [NUM_CPUS-1:0]       cpu_rst_n,
  output logic                      run,
  output logic                      done,
  output logic                      timeout,
  output logic [NUM_CPUS-1:0]       halt_mask,
  output logic [CYC_W-1:0]          cycle_count,
  output logic [NUM_CPUS*CYC_W-1:0] halt_cycles
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);

  if (NUM_CPUS < 1) begin : g_bad_num_cpus
    $error("run_controller: NUM_CPUS must be >= 1");
  end
  if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("run_controller: RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  if ((64'd1 << CYC_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cyc_w
    $error("run_controller: CYC_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [RST_W-1:0]     r_rst_cnt;
  logic [CYC_W-1:0]     r_cycle_count;
  logic                 r_timeout;
  logic                 r_halt_seen [NUM_CPUS];
  logic [CYC_W-1:0]     r_halt_cyc  [NUM_CPUS];

  logic [NUM_CPUS-1:0]  w_new_halt;
  logic                 w_all_halted;
  logic                 w_timeout_hit;
  logic                 w_enter_reset;
  logic                 w_run_stay;
  logic                 w_run_exit;
  logic                 w_set_timeout;

  // Halts only count while running; anything seen in other states is dropped.
  assign w_new_halt    = halt & ~halt_mask & {NUM_CPUS{r_state == S_RUN}};
  assign w_all_halted  = &(halt_mask | w_new_halt);
  assign w_timeout_hit = (r_cycle_count == CYC_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_enter_reset = 1'b0;
    w_run_stay    = 1'b0;
    w_run_exit    = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next  = S_RESET;
          w_enter_reset = 1'b1;
        end
      end
      S_RESET: begin
        if (r_rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // A final halt landing on the timeout cycle counts as a clean finish.
        if (w_all_halted) begin
          w_state_next = S_DONE;
          w_run_exit   = 1'b1;
        end else if (w_timeout_hit) begin
          w_state_next  = S_DONE;
          w_run_exit    = 1'b1;
          w_set_timeout = 1'b1;
        end else begin
          w_run_stay = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt     <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_enter_reset) begin
        r_rst_cnt <= '0;
      end else if (r_state == S_RESET) begin
        r_rst_cnt <= r_rst_cnt + RST_W'(1);
      end

      if (w_enter_reset) begin
        r_cycle_count <= '0;
      end else if (w_run_stay) begin
        r_cycle_count <= r_cycle_count + CYC_W'(1);
      end

      if (w_enter_reset) begin
        r_timeout <= 1'b0;
      end else if (w_run_exit) begin
        r_timeout <= w_set_timeout;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CPUS; gi++) begin : g_chan
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_halt_seen[gi] <= 1'b0;
        r_halt_cyc[gi]  <= '0;
      end else if (w_enter_reset) begin
        r_halt_seen[gi] <= 1'b0;
        r_halt_cyc[gi]  <= '0;
      end else if (w_new_halt[gi]) begin
        r_halt_seen[gi] <= 1'b1;
        r_halt_cyc[gi]  <= r_cycle_count;
      end
    end

    assign halt_mask[gi]                     = r_halt_seen[gi];
    assign halt_cycles[gi*CYC_W +: CYC_W]    = r_halt_cyc[gi];
  end

  assign cpu_rst_n   = {NUM_CPUS{r_state == S_RUN}};
  assign run         = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: each run's expected result is queued when its
// halt schedule is driven and compared when the controller reaches DONE.
module tb_run_controller;

  localparam int N  = 2;
  localparam int RC = 4;
  localparam int TO = 32;
  localparam int W  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   halt;
  logic [N-1:0]   cpu_rst_n;
  logic           run;
  logic           done;
  logic           timeout;
  logic [N-1:0]   halt_mask;
  logic [W-1:0]   cycle_count;
  logic [N*W-1:0] halt_cycles;

  run_controller #(
    .NUM_CPUS      (N),
    .RESET_CYCLES  (RC),
    .TIMEOUT_CYCLES(TO),
    .CYC_W         (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt        (halt),
    .cpu_rst_n   (cpu_rst_n),
    .run         (run),
    .done        (done),
    .timeout     (timeout),
    .halt_mask   (halt_mask),
    .cycle_count (cycle_count),
    .halt_cycles (halt_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   mask;
    logic [W-1:0]   cc;
    logic           to;
    logic [N*W-1:0] hc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_runs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Halts are single-cycle pulses sampled while cycle_count equals h0/h1; -1 means never.
  task automatic push_expected(input int h0, input int h1);
    exp_t e;
    bit   ok0;
    bit   ok1;
    ok0 = (h0 >= 0) && (h0 <= TO - 1);
    ok1 = (h1 >= 0) && (h1 <= TO - 1);
    e.mask = {ok1, ok0};
    e.hc   = '0;
    if (ok0) e.hc[0 +: W] = W'(h0);
    if (ok1) e.hc[W +: W] = W'(h1);
    if (ok0 && ok1) begin
      e.cc = W'((h0 > h1) ? h0 : h1);
      e.to = 1'b0;
    end else begin
      e.cc = W'(TO - 1);
      e.to = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    check_eq({tag, "_run"},       64'(run),       64'd0);
    check_eq({tag, "_done"},      64'(done),      64'd0);
    check_eq({tag, "_timeout"},   64'(timeout),   64'd0);
    check_eq({tag, "_mask"},      64'(halt_mask), 64'd0);
    check_eq({tag, "_cc"},        64'(cycle_count), 64'd0);
    check_eq({tag, "_hc"},        64'(halt_cycles), 64'd0);
  endtask

  task automatic run_case(input int h0, input int h1, input int start_at, input int rst_at);
    exp_t e;
    int   k;
    if (rst_at < 0) push_expected(h0, h1);
    start = 1'b1;
    halt  = '1;   // held during RESET; must not register as halts
    tick();
    start = 1'b0;
    for (int i = 1; i <= RC; i++) begin
      check_eq("reset_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check_eq("reset_run", 64'(run), 64'd0);
      if (i == 1) begin
        check_eq("reset_done_clr", 64'(done), 64'd0);
        check_eq("reset_mask_clr", 64'(halt_mask), 64'd0);
        check_eq("reset_cc_clr", 64'(cycle_count), 64'd0);
        check_eq("reset_hc_clr", 64'(halt_cycles), 64'd0);
      end
      tick();
    end
    halt = '0;
    check_eq("run_cpu_rst_n", 64'(cpu_rst_n), 64'(2'b11));
    check_eq("run_flag", 64'(run), 64'd1);

    k = 0;
    while (k < TO + 8) begin
      if (done) break;
      check_eq("run_cc", 64'(cycle_count), 64'(k));
      if (k == rst_at) begin
        halt  = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("idle_after_rst");
        $display("run %0d: aborted by reset at RUN cycle %0d", n_runs, k);
        n_runs++;
        return;
      end
      halt[0] = (k == h0);
      halt[1] = (k == h1);
      start   = (k == start_at);
      tick();
      k++;
    end
    halt  = '0;
    start = 1'b0;

    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    if (!done) begin
      check_eq("done_seen", 64'(done), 64'd1);
      return;
    end
    check_eq("done_latency", 64'(k), 64'(e.cc) + 64'd1);
    check_eq("timeout", 64'(timeout), 64'(e.to));
    check_eq("halt_mask", 64'(halt_mask), 64'(e.mask));
    check_eq("cycle_count", 64'(cycle_count), 64'(e.cc));
    check_eq("halt_cycles", 64'(halt_cycles), 64'(e.hc));
    check_eq("done_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check_eq("done_run", 64'(run), 64'd0);
    $display("run %0d: done mask=%b timeout=%0d cycle_count=%0d halt_cycles={%0d,%0d}",
             n_runs, halt_mask, timeout, cycle_count, halt_cycles[W +: W], halt_cycles[0 +: W]);
    n_runs++;
    tick();
    tick();
    check_eq("done_hold_cc", 64'(cycle_count), 64'(e.cc));
    check_eq("done_hold", 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    halt  = '0;
    repeat (3) tick();
    check_all_zero("por");
    rst_n = 1'b1;
    tick();
    check_all_zero("idle");

    run_case(10, 17, -1, -1);  // both halt, timestamps {17,10}
    run_case(5, -1, -1, -1);   // only CPU0 halts -> timeout at 31
    run_case(31, 31, -1, -1);  // halts on the timeout cycle win
    run_case(3, -1, -1, 7);    // async reset mid-run
    run_case(2, 4, -1, -1);    // clean run from IDLE after abort
    run_case(6, 12, 5, -1);    // start during RUN ignored
    run_case(20, 0, -1, -1);   // restart from DONE clears previous result

    if (sb_q.size() != 0) check_eq("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
